// File: rtl/seg_monitor.sv
// Receive-side checker for the two-digit 7-segment seconds display: filters, decodes
// and sequence-checks settled digit pairs, and counts legal 99->00 rollovers.
module seg_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int HUND_W        = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [6:0]        led_0_i,
  input  logic [6:0]        led_1_i,
  input  logic              rco_i,
  input  logic              clr_err_i,
  output logic [6:0]        value_o,
  output logic [3:0]        digit_0_o,
  output logic [3:0]        digit_1_o,
  output logic              valid_o,
  output logic              blank_o,
  output logic              step_o,
  output logic              rollover_o,
  output logic [HUND_W-1:0] hundreds_o,
  output logic              err_pattern_o,
  output logic              err_seq_o
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [6:0] DARK = 7'b1111111;

  typedef struct packed {
    logic [6:0] led_1;
    logic [6:0] led_0;
    logic       rco;
  } sample_t;

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, FAULT} state_e;

  localparam sample_t DARK_SAMPLE = '{led_1: DARK, led_0: DARK, rco: 1'b0};

  // Returns {legal, digit}; legal=0 for anything that is not one of the ten codes.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      default:    decode = 5'h00;
    endcase
  endfunction

  sample_t     in_s;
  sample_t     s1_q, s2_q, cand_q;
  logic [13:0] last_q;
  logic [CNT_W-1:0] cnt_q;
  logic        rco_seen_q;
  logic        accept;

  assign in_s = '{led_1: led_1_i, led_0: led_0_i, rco: rco_i};

  // The candidate must still match s2 at the accept edge, so a pattern has to be
  // present for STABLE_CYCLES+1 samples before it is taken.
  assign accept = (cnt_q == CNT_MAX) && (s2_q == cand_q) &&
                  ({cand_q.led_1, cand_q.led_0} != last_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q       <= DARK_SAMPLE;
      s2_q       <= DARK_SAMPLE;
      cand_q     <= DARK_SAMPLE;
      last_q     <= {DARK, DARK};
      cnt_q      <= '0;
      rco_seen_q <= 1'b0;
    end else begin
      s1_q <= in_s;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (accept) begin
        last_q <= {cand_q.led_1, cand_q.led_0};
      end
      rco_seen_q <= accept ? 1'b0 : (rco_seen_q | s2_q.rco);
    end
  end

  logic [4:0] dec_1, dec_0;
  logic       both_dark, legal, bad_pat;
  logic [6:0] new_val;
  logic       is_inc, is_wrap, is_reset, seq_bad;

  assign dec_1     = decode(cand_q.led_1);
  assign dec_0     = decode(cand_q.led_0);
  assign both_dark = (cand_q.led_1 == DARK) && (cand_q.led_0 == DARK);
  assign legal     = dec_1[4] && dec_0[4];
  assign bad_pat   = !both_dark && !legal;
  assign new_val   = 7'(dec_1[3:0]) * 7'd10 + 7'(dec_0[3:0]);

  logic [6:0] value_q, value_d;
  logic [3:0] digit_0_q, digit_0_d, digit_1_q, digit_1_d;
  logic       valid_q, valid_d, blank_q, blank_d;
  logic       step_q, step_d, rollover_q, rollover_d;
  logic [HUND_W-1:0] hundreds_q, hundreds_d;
  logic       err_pattern_q, err_pattern_d, err_seq_q, err_seq_d;
  state_e     state_q, state_d;

  assign is_inc   = (new_val == value_q + 7'd1);
  assign is_wrap  = (value_q == 7'd99) && (new_val == 7'd0) && (rco_seen_q || s2_q.rco);
  assign is_reset = (value_q != 7'd99) && (new_val == 7'd0);
  assign seq_bad  = !(is_inc || is_wrap || is_reset);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (both_dark) begin
        state_d = (state_q == FAULT) ? ACQUIRE : IDLE;
      end else if (legal) begin
        case (state_q)
          IDLE: state_d = ACQUIRE;
          ACQUIRE, TRACK: begin
            if (is_inc || is_wrap) begin
              state_d = TRACK;
            end else if (is_reset) begin
              state_d = ACQUIRE;
            end else begin
              state_d = FAULT;
            end
          end
          FAULT: state_d = (new_val == 7'd0) ? ACQUIRE : FAULT;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Error events are applied after clr_err so a same-cycle event keeps its flag set.
  always_comb begin
    value_d       = value_q;
    digit_0_d     = digit_0_q;
    digit_1_d     = digit_1_q;
    valid_d       = valid_q;
    blank_d       = blank_q;
    step_d        = 1'b0;
    rollover_d    = 1'b0;
    hundreds_d    = hundreds_q;
    err_pattern_d = clr_err_i ? 1'b0 : err_pattern_q;
    err_seq_d     = clr_err_i ? 1'b0 : err_seq_q;
    if (accept) begin
      if (both_dark) begin
        blank_d = 1'b1;
        valid_d = 1'b0;
      end else if (bad_pat) begin
        err_pattern_d = 1'b1;
      end else begin
        value_d   = new_val;
        digit_0_d = dec_0[3:0];
        digit_1_d = dec_1[3:0];
        valid_d   = 1'b1;
        blank_d   = 1'b0;
        step_d    = 1'b1;
        if (state_q == ACQUIRE || state_q == TRACK) begin
          if (is_wrap) begin
            rollover_d = 1'b1;
            hundreds_d = hundreds_q + HUND_W'(1);
          end else if (seq_bad) begin
            err_seq_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q       <= '0;
      digit_0_q     <= '0;
      digit_1_q     <= '0;
      valid_q       <= 1'b0;
      blank_q       <= 1'b0;
      step_q        <= 1'b0;
      rollover_q    <= 1'b0;
      hundreds_q    <= '0;
      err_pattern_q <= 1'b0;
      err_seq_q     <= 1'b0;
    end else begin
      value_q       <= value_d;
      digit_0_q     <= digit_0_d;
      digit_1_q     <= digit_1_d;
      valid_q       <= valid_d;
      blank_q       <= blank_d;
      step_q        <= step_d;
      rollover_q    <= rollover_d;
      hundreds_q    <= hundreds_d;
      err_pattern_q <= err_pattern_d;
      err_seq_q     <= err_seq_d;
    end
  end

  assign value_o       = value_q;
  assign digit_0_o     = digit_0_q;
  assign digit_1_o     = digit_1_q;
  assign valid_o       = valid_q;
  assign blank_o       = blank_q;
  assign step_o        = step_q;
  assign rollover_o    = rollover_q;
  assign hundreds_o    = hundreds_q;
  assign err_pattern_o = err_pattern_q;
  assign err_seq_o     = err_seq_q;

endmodule

// File: doc/seg_monitor.md
# seg_monitor

Receive-side checker for the two-digit seconds display. It samples the active-low 7-segment buses and the RCO carry driven by the 00-99 seconds counter, and decodes each settled pair of patterns back to a binary value. It also checks that successive values follow the counter's legal sequence and accumulates completed hundreds from 99→00 rollovers. It sits on the same 50 MHz clock as the counter and feeds status LEDs and the lab self-check logic.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples needed to accept a pattern pair (≥1)
- HUND_W, 8: width of the rollover accumulator
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-high reset
- led_0  in  7  ones-digit pattern, active-low, bit order {g,f,e,d,c,b,a}
- led_1  in  7  tens-digit pattern, same encoding
- rco  in  1  carry from counter, level (high for the whole 00 period after wrap)
- clr_err  in  1  synchronous clear of sticky error flags
- value  out  7  accepted count, binary 0-99
- digit_0, digit_1  out  4  accepted BCD digits
- valid  out  1  value holds a decoded count
- blank  out  1  both displays dark (1111111) and accepted
- step  out  1  one-cycle pulse per newly accepted value
- rollover  out  1  one-cycle pulse on legal 99→00
- hundreds  out  HUND_W  rollover count, wraps modulo 2^HUND_W
- err_pattern  out  1  sticky: illegal or half-blank pattern accepted
- err_seq  out  1  sticky: illegal value transition

## Operation
- Legal digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Dark=1111111.
- Input path: {led_1, led_0, rco} go through a 2-flop register chain (s1, s2). A candidate register plus a stability counter follow the chain. When s2 differs from the candidate, the candidate loads s2 and the counter clears. Otherwise the counter counts up, saturating at STABLE_CYCLES-1.
- Acceptance: a pattern pair is accepted once, in the cycle after the counter reaches STABLE_CYCLES-1, and only if the pair differs from the last accepted pair.
- rco_seen: set whenever s2.rco=1; cleared on each acceptance.
- FSM states: IDLE, ACQUIRE, TRACK, FAULT.
  - IDLE (reset): valid=0.
  - Accept dark/dark → blank=1, valid=0, go to IDLE.
  - Accept two legal digits in IDLE → load value, valid=1, step pulse, go to ACQUIRE. No sequence check is made.
  - ACQUIRE/TRACK, new legal value v after previous p:
    - v=p+1 → step, go to TRACK.
    - p=99, v=0, and rco_seen or s2.rco → step, rollover, hundreds+1.
    - p≠99, v=0 → counter reset: step, go to ACQUIRE, no error.
    - Anything else → err_seq=1, value still updates, step pulses, go to FAULT.
  - FAULT: updates value like ACQUIRE but makes no sequence checks. It leaves to ACQUIRE on the next 00 or dark accept.
  - Any state: an accepted pair with an illegal code, or exactly one dark digit → err_pattern=1. value and valid hold; state is unchanged.
- clr_err clears both sticky flags. An error event in the same cycle wins over clr_err, so the flag stays set.
- value equals digit_1*10+digit_0; 7-bit result, no overflow possible.

## Timing
- Reset values: value=0, digit_0=0, digit_1=0, valid=0, blank=0, step=0, rollover=0, hundreds=0, err_pattern=0, err_seq=0; FSM=IDLE; stability counter=0.
- Candidate and last-accepted registers reset to dark/dark with rco=0. A dark display right after reset therefore produces no acceptance and blank stays 0.
- Latency: inputs stable from edge k → s1 at k, s2 at k+1, candidate at k+2. Outputs and step/rollover pulses are registered at edge k+2+STABLE_CYCLES.
- step and rollover are high exactly one cycle per acceptance. A held input never re-pulses.
- A pattern glitch shorter than STABLE_CYCLES+1 cycles produces no acceptance and no error.
- Reset asserted mid-filter or mid-FAULT forces all reset values immediately (asynchronously). After release, the first accepted value is handled from IDLE.
- hundreds wraps from 2^HUND_W-1 to 0 without error.

## Test plan
- Reset, then drive pattern 0 (both digits) held 10 cycles → valid=1, value=0, step once at edge 6 after change (STABLE_CYCLES=4), state ACQUIRE.
- Drive 00→01→…→99→00 with rco=1 during the final 00 → 100 steps, value tracks, rollover once, hundreds=1, no errors.
- Drive 99→00 with rco=0 → err_seq=1, rollover=0, hundreds unchanged. Then clr_err → err_seq=0.
- Drive 57→58→00 (counter reset) → no error. Drive 58→60 → err_seq=1; the next 00 returns the FSM to ACQUIRE.
- Glitch led_0 from 1111001 to 0000000 for 3 cycles → no step, value unchanged. Hold 1111011 for 10 cycles → err_pattern=1, value held.
- Drive dark/dark after 42 → blank=1, valid=0. Assert rst mid-stability-count → all outputs return to reset values immediately.
